// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : Load/store sequencer for a word-wide data memory with sub-word
//            extraction and read-modify-write SB/SH. Optional macro
//            DMEM_MISALIGN_TRAP_EN turns misaligned H/HU/W into errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl #(
    parameter int MEM_WORDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    output logic        o_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_a,
    output logic [31:0] o_mem_wd,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rd
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;

    logic        w_is_half;
    logic        w_is_word;
    logic        w_illegal;
    logic        w_misal;
    logic        w_misal_err;
    logic [31:0] w_addr_eff;
    logic        w_oor;
    logic        w_reject;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic [31:0] w_merge;

    assign w_is_half = (i_req_funct3[1:0] == 2'b01);
    assign w_is_word = (i_req_funct3[1:0] == 2'b10);
    assign w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11) ||
                       (i_req_funct3[2] && i_req_we);
    assign w_misal   = (w_is_half && i_req_addr[0]) ||
                       (w_is_word && (i_req_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misal_err = w_misal;
    assign w_addr_eff  = i_req_addr;
`else
    // Misaligned accesses are silently rounded down before the range check
    assign w_misal_err = 1'b0;
    assign w_addr_eff  = w_is_word ? {i_req_addr[31:2], 2'b00} :
                         w_is_half ? {i_req_addr[31:1], 1'b0}  : i_req_addr;
`endif

    assign w_oor    = (w_addr_eff[31:2] >= 30'(MEM_WORDS));
    assign w_reject = w_illegal || w_misal_err || w_oor;

    assign w_byte = i_mem_rd[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];

    always_comb begin
        w_ext = i_mem_rd;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = i_mem_rd;
        endcase
    end

    always_comb begin
        w_merge = r_buf;
        if (r_funct3[1:0] == 2'b00)
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_buf    <= 32'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we     <= i_req_we;
                        r_funct3 <= i_req_funct3;
                        r_addr   <= w_addr_eff;
                        r_wdata  <= i_req_wdata;
                        if (w_reject) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (i_req_we && !w_is_word) begin
                            r_state <= S_RMW_RD;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we)
                        r_rdata <= w_ext;
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_RMW_RD: begin
                    r_buf   <= i_mem_rd;
                    r_state <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write enable is decoded from state so an async reset kills it at once
    assign o_mem_we = ((r_state == S_ACCESS) && r_we) || (r_state == S_RMW_WR);
    assign o_mem_a  = (r_state == S_IDLE) ? 32'd0 : {r_addr[31:2], 2'b00};
    assign o_mem_wd = (r_state == S_RMW_WR)          ? w_merge :
                      ((r_state == S_ACCESS) && r_we) ? r_wdata : 32'd0;

    assign o_ready = (r_state == S_IDLE);
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Brief    : Directed self-checking bench for dmem_access_ctrl with a small
//            behavioural word memory attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'd0;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic [31:0] o_mem_a;
    logic [31:0] o_mem_wd;
    logic        o_mem_we;
    logic [31:0] i_mem_rd;

    logic [31:0] mem [0:31];
    logic        preload = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rec_we [0:8];
    logic [31:0] rec_a  [0:8];
    logic [31:0] rec_wd [0:8];
    logic        any_we;
    logic [31:0] exp_word2;

    dmem_access_ctrl #(.MEM_WORDS(31)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_valid  (i_req_valid),
        .o_ready      (o_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_rdata      (o_rdata),
        .o_mem_a      (o_mem_a),
        .o_mem_wd     (o_mem_wd),
        .o_mem_we     (o_mem_we),
        .i_mem_rd     (i_mem_rd)
    );

    always #5 clk = ~clk;

    assign i_mem_rd = (o_mem_a[31:2] < 30'd31) ? mem[o_mem_a[6:2]] : 32'd0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            mem[1] <= 32'h1122_3344;
            mem[2] <= 32'hA1B2_C3D4;
        end else if (o_mem_we && (o_mem_a[31:2] < 30'd31)) begin
            mem[o_mem_a[6:2]] <= o_mem_wd;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Issues one request, records per-cycle memory signals, checks latency/err/rdata
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic exp_err,
                           input logic chk_rd, input logic [31:0] exp_rd);
        int lat;
        lat    = -1;
        any_we = 1'b0;
        @(negedge clk);
        chk_eq({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        @(posedge clk); #1;
        i_req_valid  = 1'b0;
        i_req_addr   = 32'hFFFF_FFFF;
        i_req_wdata  = 32'hDEAD_BEEF;
        for (int k = 1; k <= 8; k++) begin
            rec_we[k] = o_mem_we;
            rec_a[k]  = o_mem_a;
            rec_wd[k] = o_mem_wd;
            any_we    = any_we | o_mem_we;
            if (o_done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        chk_eq({tag, "_lat"}, lat, exp_lat);
        chk_eq({tag, "_err"}, {31'd0, o_err}, {31'd0, exp_err});
        if (chk_rd)
            chk_eq({tag, "_rdata"}, o_rdata, exp_rd);
        @(posedge clk); #1;
        chk_eq({tag, "_pulse"}, {30'd0, o_done, o_ready}, 32'd1);
    endtask

    initial begin
        logic [6:0]  donev;
        logic [31:0] rd2;
        logic [31:0] rd5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        chk_eq("rst_ready", {31'd0, o_ready}, 32'd1);
        chk_eq("rst_done",  {30'd0, o_done, o_err}, 32'd0);
        chk_eq("rst_rdata", o_rdata, 32'd0);
        chk_eq("rst_mem",   {31'd0, o_mem_we} | o_mem_a | o_mem_wd, 32'd0);
        rst = 1'b0;

        run_req("lb",  1'b0, 3'b000, 32'h08, 32'd0, 2, 1'b0, 1'b1, 32'hFFFF_FFD4);
        run_req("lbu", 1'b0, 3'b100, 32'h09, 32'd0, 2, 1'b0, 1'b1, 32'h0000_00C3);
        run_req("lh",  1'b0, 3'b001, 32'h0A, 32'd0, 2, 1'b0, 1'b1, 32'hFFFF_A1B2);
        run_req("lhu", 1'b0, 3'b101, 32'h08, 32'd0, 2, 1'b0, 1'b1, 32'h0000_C3D4);

        run_req("sb", 1'b1, 3'b000, 32'h09, 32'h1234_56EE, 3, 1'b0, 1'b1, 32'h0000_C3D4);
        chk_eq("sb_rd_we",  {31'd0, rec_we[1]}, 32'd0);
        chk_eq("sb_wr_we",  {31'd0, rec_we[2]}, 32'd1);
        chk_eq("sb_wr_a",   rec_a[2],  32'h08);
        chk_eq("sb_wr_wd",  rec_wd[2], 32'hA1B2_EED4);
        chk_eq("sb_mem",    mem[2],    32'hA1B2_EED4);
        run_req("lw", 1'b0, 3'b010, 32'h08, 32'd0, 2, 1'b0, 1'b1, 32'hA1B2_EED4);

`ifdef DMEM_MISALIGN_TRAP_EN
        exp_word2 = 32'hA1B2_EED4;
        run_req("sh_mis", 1'b1, 3'b001, 32'h09, 32'h0000_BEEF, 1, 1'b1, 1'b0, 32'd0);
        chk_eq("sh_mis_we", {31'd0, any_we}, 32'd0);
        run_req("lw_mis", 1'b0, 3'b010, 32'h0A, 32'd0, 1, 1'b1, 1'b1, 32'hA1B2_EED4);
`else
        exp_word2 = 32'hA1B2_BEEF;
        run_req("sh_mis", 1'b1, 3'b001, 32'h09, 32'h0000_BEEF, 3, 1'b0, 1'b0, 32'd0);
        run_req("lw_mis", 1'b0, 3'b010, 32'h0A, 32'd0, 2, 1'b0, 1'b1, 32'hA1B2_BEEF);
`endif
        chk_eq("sh_mis_mem", mem[2], exp_word2);

        run_req("lw_oor", 1'b0, 3'b010, 32'h7C, 32'd0, 1, 1'b1, 1'b0, 32'd0);
        chk_eq("lw_oor_we", {31'd0, any_we}, 32'd0);
        run_req("f3_011", 1'b0, 3'b011, 32'h00, 32'd0, 1, 1'b1, 1'b0, 32'd0);
        run_req("sbu", 1'b1, 3'b100, 32'h00, 32'h5555_5555, 1, 1'b1, 1'b0, 32'd0);
        chk_eq("sbu_we",  {31'd0, any_we}, 32'd0);
        chk_eq("sbu_mem", mem[0], 32'd0);

        // Reset asserted while the RMW write is on the bus
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b000;
        i_req_addr   = 32'h04;
        i_req_wdata  = 32'h0000_00FF;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(posedge clk); #1;
        chk_eq("rmw_we_pre", {31'd0, o_mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk_eq("rmw_rst_we",    {31'd0, o_mem_we}, 32'd0);
        chk_eq("rmw_rst_state", {30'd0, o_ready, o_done}, 32'd2);
        chk_eq("rmw_rst_rdata", o_rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_eq("rmw_rst_mem", mem[1], 32'h1122_3344);
        run_req("lw_post", 1'b0, 3'b010, 32'h04, 32'd0, 2, 1'b0, 1'b1, 32'h1122_3344);

        // Two loads with req_valid held high across both
        @(negedge clk);
        i_req_valid  = 1'b1;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h08;
        @(posedge clk); #1;
        i_req_addr = 32'h04;
        donev = 7'd0;
        rd2   = 32'd0;
        rd5   = 32'd0;
        for (int k = 1; k <= 6; k++) begin
            donev[k] = o_done;
            if (k == 2) rd2 = o_rdata;
            if (k == 5) rd5 = o_rdata;
            if (k == 4) i_req_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk_eq("b2b_done", {25'd0, donev}, 32'b010_0100);
        chk_eq("b2b_rd1",  rd2, exp_word2);
        chk_eq("b2b_rd2",  rd5, 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
